mem_req_arbiter: RTL and testbench

Shares one downstream SRAM-like memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write).
It sits between the pipeline stages (IF and EX/MEM) and the future AXI bridge.
It grants the port one address handshake at a time, tracks outstanding transactions in order, and returns each response to its owner.
Transactions are split, with address and data phases handshaked separately.

---
 rtl/mem_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Shares one split-handshake SRAM-like memory port between the
//                instruction-fetch requester (read-only) and the load/store
//                requester. It grants one address handshake at a time with
//                round-robin priority and records the owner of each accepted
//                transaction in an in-order FIFO. Each response is routed back
//                to the owner at the FIFO head.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   // instruction fetch side
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // load/store side
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // downstream memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

   // Owner tags stored in the FIFO and in the round-robin pointer.
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic                    last_gnt_q, last_gnt_d;
   logic [OUTSTANDING-1:0]  owner_q, owner_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;

   logic                    push;
   logic                    push_owner;
   logic                    pop;
   logic                    head_owner;
   logic                    fifo_full;

   assign fifo_full  = (count_q == FULL_CNT);
   assign head_owner = owner_q[rd_ptr_q];
   // A response with nothing outstanding is dropped without touching state.
   assign pop        = mem_data_ok && (count_q != '0);

   // Read data is passed straight through; data_ok qualifies it.
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign inst_data_ok = pop && (head_owner == OWNER_INST);
   assign data_data_ok = pop && (head_owner == OWNER_DATA);

   // Grant FSM: next state, downstream drive and address handshakes.
   always_comb begin
      state_d      = state_q;
      last_gnt_d   = last_gnt_q;
      push         = 1'b0;
      push_owner   = OWNER_INST;
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_wstrb    = 4'h0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Grant is registered, so the port is always idle for one cycle
            // between handshakes; a full FIFO blocks new grants entirely.
            if (!fifo_full) begin
               if (inst_req && data_req) begin
                  state_d = (last_gnt_q == OWNER_INST) ? GNT_D : GNT_I;
               end else if (inst_req) begin
                  state_d = GNT_I;
               end else if (data_req) begin
                  state_d = GNT_D;
               end
            end
         end
         GNT_I: begin
            mem_req      = 1'b1;
            mem_addr     = inst_addr;
            inst_addr_ok = mem_addr_ok;
            if (mem_addr_ok) begin
               push       = 1'b1;
               push_owner = OWNER_INST;
               last_gnt_d = OWNER_INST;
               state_d    = IDLE;
            end
         end
         GNT_D: begin
            mem_req      = 1'b1;
            mem_wr       = data_wr;
            mem_wstrb    = data_wr ? data_wstrb : 4'h0;
            mem_addr     = data_addr;
            mem_wdata    = data_wdata;
            data_addr_ok = mem_addr_ok;
            if (mem_addr_ok) begin
               push       = 1'b1;
               push_owner = OWNER_DATA;
               last_gnt_d = OWNER_DATA;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Owner FIFO bookkeeping: pointers wrap naturally at the power-of-2 depth.
   always_comb begin
      owner_d  = owner_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         owner_d[wr_ptr_q] = push_owner;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // State registers with asynchronous flush of the grant and the FIFO.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         last_gnt_q <= OWNER_INST;
         owner_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_arbiter
//  Description : Directed self-checking bench for mem_req_arbiter. Inputs are
//                driven on the falling clock edge and outputs are sampled 1ns
//                later, well away from the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int n_checks;
   int n_errors;

   mem_req_arbiter #(.OUTSTANDING(2)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Move to the next falling edge, where stimulus is applied.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      next_cycle();
      resetn = 1'b0;
      next_cycle();
      resetn = 1'b1;
   endtask

   logic [31:0] exp_addr [4];
   logic        exp_is_data [4];

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      resetn      = 1'b1;
      inst_req    = 1'b0;
      inst_addr   = 32'h0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_wstrb  = 4'h0;
      data_addr   = 32'h0;
      data_wdata  = 32'h0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;

      // ---------------- reset state ----------------
      #1 resetn = 1'b0;
      #1;
      check_val("rst_mem_req",      32'(mem_req),      32'd0);
      check_val("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      check_val("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
      check_val("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
      check_val("rst_data_data_ok", 32'(data_data_ok), 32'd0);
      mem_rdata = 32'hA5A5_A5A5;
      #1;
      check_val("rst_inst_rdata_pass", inst_rdata, 32'hA5A5_A5A5);
      check_val("rst_data_rdata_pass", data_rdata, 32'hA5A5_A5A5);
      next_cycle();
      resetn = 1'b1;

      // ---------------- single fetch ----------------
      next_cycle();
      inst_req  = 1'b1;
      inst_addr = 32'h1C00_0000;
      #1 check_val("sf_idle_no_req", 32'(mem_req), 32'd0);
      next_cycle();
      mem_addr_ok = 1'b1;
      #1;
      check_val("sf_gnt_req",     32'(mem_req),      32'd1);
      check_val("sf_gnt_addr",    mem_addr,          32'h1C00_0000);
      check_val("sf_gnt_wr",      32'(mem_wr),       32'd0);
      check_val("sf_inst_addrok", 32'(inst_addr_ok), 32'd1);
      check_val("sf_data_addrok", 32'(data_addr_ok), 32'd0);
      next_cycle();
      inst_req    = 1'b0;
      mem_addr_ok = 1'b0;
      #1 check_val("sf_req_one_cycle", 32'(mem_req), 32'd0);
      next_cycle();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0280_0C0C;
      #1;
      check_val("sf_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check_val("sf_inst_rdata",   inst_rdata,        32'h0280_0C0C);
      check_val("sf_data_data_ok", 32'(data_data_ok), 32'd0);
      next_cycle();
      mem_data_ok = 1'b0;

      // ---------------- contention / round-robin ----------------
      pulse_reset();
      exp_addr[0] = 32'h0000_0200; exp_is_data[0] = 1'b1;
      exp_addr[1] = 32'h0000_0100; exp_is_data[1] = 1'b0;
      exp_addr[2] = 32'h0000_0200; exp_is_data[2] = 1'b1;
      exp_addr[3] = 32'h0000_0100; exp_is_data[3] = 1'b0;
      inst_req    = 1'b1;
      inst_addr   = 32'h0000_0100;
      data_req    = 1'b1;
      data_wr     = 1'b0;
      data_addr   = 32'h0000_0200;
      mem_addr_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         // bubble cycle; drain the previous grant's response here
         mem_data_ok = (k > 0);
         #1;
         check_val($sformatf("rr_bubble%0d_req", k), 32'(mem_req), 32'd0);
         if (k > 0) begin
            check_val($sformatf("rr_rsp%0d_inst", k), 32'(inst_data_ok), 32'(!exp_is_data[k-1]));
            check_val($sformatf("rr_rsp%0d_data", k), 32'(data_data_ok), 32'(exp_is_data[k-1]));
         end
         next_cycle();
         mem_data_ok = 1'b0;
         #1;
         check_val($sformatf("rr_gnt%0d_req", k),  32'(mem_req), 32'd1);
         check_val($sformatf("rr_gnt%0d_addr", k), mem_addr,     exp_addr[k]);
         check_val($sformatf("rr_gnt%0d_daok", k), 32'(data_addr_ok), 32'(exp_is_data[k]));
         next_cycle();
      end
      inst_req    = 1'b0;
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      #1 check_val("rr_last_rsp_inst", 32'(inst_data_ok), 32'd1);
      next_cycle();
      mem_data_ok = 1'b0;

      // ---------------- store routing ----------------
      data_req   = 1'b1;
      data_wr    = 1'b1;
      data_wstrb = 4'hF;
      data_addr  = 32'h1C00_8000;
      data_wdata = 32'hDEAD_BEEF;
      #1 check_val("st_idle_no_req", 32'(mem_req), 32'd0);
      next_cycle();
      mem_addr_ok = 1'b1;
      #1;
      check_val("st_mem_wr",    32'(mem_wr),       32'd1);
      check_val("st_mem_wstrb", 32'(mem_wstrb),    32'hF);
      check_val("st_mem_wdata", mem_wdata,         32'hDEAD_BEEF);
      check_val("st_mem_addr",  mem_addr,          32'h1C00_8000);
      check_val("st_daddr_ok",  32'(data_addr_ok), 32'd1);
      check_val("st_iaddr_ok",  32'(inst_addr_ok), 32'd0);
      next_cycle();
      data_req    = 1'b0;
      data_wr     = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      #1;
      check_val("st_rsp_data_ok", 32'(data_data_ok), 32'd1);
      check_val("st_rsp_inst_ok", 32'(inst_data_ok), 32'd0);
      next_cycle();
      mem_data_ok = 1'b0;

      // ---------------- FIFO full ----------------
      inst_req    = 1'b1;
      inst_addr   = 32'h1C00_0040;
      mem_addr_ok = 1'b1;
      next_cycle();           // first grant
      #1 check_val("ff_gnt0", 32'(mem_req), 32'd1);
      next_cycle();           // bubble
      next_cycle();           // second grant
      #1 check_val("ff_gnt1", 32'(mem_req), 32'd1);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         #1 check_val($sformatf("ff_blocked%0d", k), 32'(mem_req), 32'd0);
      end
      next_cycle();
      mem_data_ok = 1'b1;
      #1 check_val("ff_pop_inst_ok", 32'(inst_data_ok), 32'd1);
      next_cycle();
      mem_data_ok = 1'b0;
      #1 check_val("ff_resume_bubble", 32'(mem_req), 32'd0);
      next_cycle();
      #1 check_val("ff_resume_gnt", 32'(mem_req), 32'd1);
      next_cycle();
      inst_req    = 1'b0;
      mem_addr_ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_data_ok = 1'b1;
         #1 check_val($sformatf("ff_drain%0d", k), 32'(inst_data_ok), 32'd1);
         next_cycle();
      end
      mem_data_ok = 1'b0;

      // ---------------- in-order response routing ----------------
      inst_req    = 1'b1;
      inst_addr   = 32'h0000_A000;
      mem_addr_ok = 1'b1;
      next_cycle();
      #1 check_val("ord_fetch_addr", mem_addr, 32'h0000_A000);
      next_cycle();
      inst_req   = 1'b0;
      data_req   = 1'b1;
      data_wr    = 1'b0;
      data_wstrb = 4'hF;
      data_addr  = 32'h0000_B000;
      next_cycle();
      #1;
      check_val("ord_load_addr",  mem_addr,          32'h0000_B000);
      check_val("ord_load_wr",    32'(mem_wr),       32'd0);
      check_val("ord_load_wstrb", 32'(mem_wstrb),    32'd0);
      next_cycle();
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h1111_1111;
      #1;
      check_val("ord_rsp0_inst_ok", 32'(inst_data_ok), 32'd1);
      check_val("ord_rsp0_data_ok", 32'(data_data_ok), 32'd0);
      check_val("ord_rsp0_rdata",   inst_rdata,        32'h1111_1111);
      next_cycle();
      mem_rdata = 32'h2222_2222;
      #1;
      check_val("ord_rsp1_data_ok", 32'(data_data_ok), 32'd1);
      check_val("ord_rsp1_inst_ok", 32'(inst_data_ok), 32'd0);
      check_val("ord_rsp1_rdata",   data_rdata,        32'h2222_2222);
      next_cycle();
      mem_data_ok = 1'b0;

      // ---------------- async reset mid-grant ----------------
      // leave one fetch outstanding so the flush is observable
      inst_req    = 1'b1;
      inst_addr   = 32'h0000_C000;
      mem_addr_ok = 1'b1;
      next_cycle();
      next_cycle();
      inst_req    = 1'b0;
      mem_addr_ok = 1'b0;
      data_req    = 1'b1;
      data_addr   = 32'h0000_D000;
      next_cycle();
      #1 check_val("ar_gnt_d_req", 32'(mem_req), 32'd1);
      #1 resetn = 1'b0;       // mid low phase, no clock edge
      #1;
      check_val("ar_req_drop",    32'(mem_req),      32'd0);
      check_val("ar_daddr_ok",    32'(data_addr_ok), 32'd0);
      next_cycle();
      data_req = 1'b0;
      resetn   = 1'b1;
      next_cycle();
      mem_data_ok = 1'b1;
      #1;
      check_val("ar_stray_inst_ok", 32'(inst_data_ok), 32'd0);
      check_val("ar_stray_data_ok", 32'(data_data_ok), 32'd0);
      next_cycle();
      mem_data_ok = 1'b0;
      // arbiter is usable again after the flush
      inst_req    = 1'b1;
      mem_addr_ok = 1'b1;
      next_cycle();
      #1 check_val("ar_post_gnt", 32'(mem_req), 32'd1);
      next_cycle();
      inst_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      #1 check_val("ar_post_rsp", 32'(inst_data_ok), 32'd1);
      next_cycle();
      mem_data_ok = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
